// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: producer/consumer handshake bundle for the skid pipeline register
interface pipe_skid_reg_if #(parameter int WIDTH = 8);
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry valid/ready skid buffer with flop-driven handshake outputs
module pipe_skid_reg #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             reset,
    pipe_skid_reg_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             in_fire;
    logic             out_fire;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    // State and handshake flags; ready/valid are registered copies of the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= next_state;
            in_ready_q  <= (next_state != FULL);
            out_valid_q <= (next_state != EMPTY);
        end
    end

    // Next state from the two fire events; flush overrides everything
    always_comb begin
        next_state = state;
        case (state)
            EMPTY:   next_state = in_fire ? BUSY : EMPTY;
            BUSY:    next_state = (in_fire && !out_fire) ? FULL :
                                  (out_fire && !in_fire) ? EMPTY : BUSY;
            FULL:    next_state = out_fire ? BUSY : FULL;
            default: next_state = EMPTY;
        endcase
        if (bus.flush) next_state = EMPTY;
    end

    // Data-path steering; flush suppresses loads so out_data stays put
    always_comb begin
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = (state == FULL);
        case (state)
            EMPTY:   load_main = in_fire;
            BUSY:    begin
                load_main = in_fire && out_fire;
                load_skid = in_fire && !out_fire;
            end
            FULL:    load_main = out_fire;
            default: load_main = 1'b0;
        endcase
        if (bus.flush) begin
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    // Main and skid data registers; hold when not loaded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) main_q <= main_from_skid ? skid_q : bus.in_data;
            if (load_skid) skid_q <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.count     = state;
endmodule
